// File: rtl/fp_div_iter_if.sv
// Handshake/data bundle for the iterative FP divider.
// Parametrised by exponent and stored-fraction width to match the divider instance.
interface fp_div_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  // start is sampled only while busy=0; an accepted start captures A/B on that edge.
  // busy stays high until the edge that raises done; done is a one-cycle pulse and
  // Out plus all flags are valid from that cycle and held until the next done.
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Out;
  logic         f_invalid;
  logic         f_divzero;
  logic         f_overflow;
  logic         f_underflow;
  logic         f_inexact;

  modport master (
    output start, A, B,
    input  busy, done, Out, f_invalid, f_divzero, f_overflow, f_underflow, f_inexact
  );

  modport slave (
    input  start, A, B,
    output busy, done, Out, f_invalid, f_divzero, f_overflow, f_underflow, f_inexact
  );
endinterface

// File: rtl/fp_div_iter.sv
// Multi-cycle floating-point divider: restoring division, one quotient bit per clock,
// DAZ on inputs, flush-to-zero on underflow, round-to-nearest-even.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_div_iter_if.slave bus,
  output logic [1:0]   state_dbg
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(MAN_W + 2);
  localparam logic signed [EW-1:0] BIAS      = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX     = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE     = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, DIV, ROUND} state_t;

  state_t state, state_nx;

  logic [W-1:0]           a_q, b_q;
  logic [MAN_W+1:0]       rem;
  logic [MAN_W:0]         dvs;
  logic [MAN_W+2:0]       q;
  logic signed [EW-1:0]   e;
  logic                   sign;
  logic                   special;
  logic [W-1:0]           spec_out;
  logic [4:0]             spec_flags;
  logic [CNT_W-1:0]       cnt;
  logic [W-1:0]           out_q;
  logic [4:0]             flags_q;  // {invalid, divzero, overflow, underflow, inexact}
  logic                   done_q;

  // Operand classification (subnormals read as zero)
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_ab;

  assign ea      = a_q[W-2:MAN_W];
  assign eb      = b_q[W-2:MAN_W];
  assign fa      = a_q[MAN_W-1:0];
  assign fb      = b_q[MAN_W-1:0];
  assign a_nan   = (&ea) && (|fa);
  assign b_nan   = (&eb) && (|fb);
  assign a_inf   = (&ea) && !(|fa);
  assign b_inf   = (&eb) && !(|fb);
  assign a_zero  = ~|ea;
  assign b_zero  = ~|eb;
  assign sign_ab = a_q[W-1] ^ b_q[W-1];

  logic         spec_hit;
  logic [W-1:0] spec_val;
  logic [4:0]   spec_fl;

  always_comb begin
    spec_hit = 1'b1;
    spec_val = '0;
    spec_fl  = '0;
    if (a_nan || b_nan) begin
      spec_val = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val = QNAN;
      spec_fl  = 5'b10000;
    end else if (a_inf) begin
      spec_val = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_val = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_fl  = 5'b01000;
    end else if (a_zero || b_inf) begin
      spec_val = {sign_ab, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring step; the remainder always stays below twice the divisor
  logic             rem_ge;
  logic [MAN_W+1:0] rem_sub;
  logic [MAN_W+1:0] rem_next;
  logic [MAN_W+2:0] q_next;

  assign rem_ge   = rem >= {1'b0, dvs};
  assign rem_sub  = rem_ge ? (rem - {1'b0, dvs}) : rem;
  assign rem_next = rem_sub << 1;
  assign q_next   = {q[MAN_W+1:0], rem_ge};

  logic [MAN_W-1:0]     frac, frac_r;
  logic                 guard, sticky, round_up, carry;
  logic signed [EW-1:0] e_n, e_r;
  logic [W-1:0]         rnd_out;
  logic [4:0]           rnd_fl;

  always_comb begin
    if (q[MAN_W+2]) begin
      frac   = q[MAN_W+1:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
      e_n    = e;
    end else begin
      frac   = q[MAN_W:1];
      guard  = q[0];
      sticky = |rem;
      e_n    = e - E_ONE;
    end
    round_up        = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    e_r             = carry ? (e_n + E_ONE) : e_n;
    if (!e_r[EW-1] && (e_r >= E_MAX)) begin
      rnd_out = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_fl  = 5'b00101;
    end else if (e_r[EW-1] || (e_r == '0)) begin
      rnd_out = {sign, {(W-1){1'b0}}};
      rnd_fl  = 5'b00011;
    end else begin
      rnd_out = {sign, e_r[EXP_W-1:0], frac_r};
      rnd_fl  = {4'b0000, guard | sticky};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = PREP;
      PREP:    state_nx = spec_hit ? ROUND : DIV;
      DIV:     if (cnt == LAST_ITER) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rem        <= '0;
      dvs        <= '0;
      q          <= '0;
      e          <= '0;
      sign       <= 1'b0;
      special    <= 1'b0;
      spec_out   <= '0;
      spec_flags <= '0;
      cnt        <= '0;
      out_q      <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q <= bus.A;
            b_q <= bus.B;
          end
        end
        PREP: begin
          special    <= spec_hit;
          spec_out   <= spec_val;
          spec_flags <= spec_fl;
          sign       <= sign_ab;
          rem        <= {2'b01, fa};
          dvs        <= {1'b1, fb};
          q          <= '0;
          e          <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          cnt        <= '0;
        end
        DIV: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
        end
        ROUND: begin
          out_q   <= special ? spec_out : rnd_out;
          flags_q <= special ? spec_flags : rnd_fl;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.Out         = out_q;
  assign bus.f_invalid   = flags_q[4];
  assign bus.f_divzero   = flags_q[3];
  assign bus.f_overflow  = flags_q[2];
  assign bus.f_underflow = flags_q[1];
  assign bus.f_inexact   = flags_q[0];
  assign state_dbg       = state;
endmodule
